// File: rtl/command_word_sequencer.sv
// rtl/command_word_sequencer.sv - 8259A bus-cycle to ICW/OCW write-flag, read-enable and INTA sequencer
module command_word_sequencer (
  input  logic       clk,
  input  logic       rstN,
  input  logic       csN,
  input  logic       wrN,
  input  logic       rdN,
  input  logic       A0,
  input  logic [7:0] DBus,
  input  logic       intaN,
  output logic [7:0] wrData,
  output logic       ICW1flag,
  output logic       ICW2flag,
  output logic       ICW3flag,
  output logic       ICW4flag,
  output logic       OCW1flag,
  output logic       OCW2flag,
  output logic       OCW3flag,
  output logic       rden,
  output logic       initDone,
  output logic       inta1,
  output logic       inta2,
  output logic       vectorOE
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_ICW2 = 3'd1,
    WAIT_ICW3 = 3'd2,
    WAIT_ICW4 = 3'd3,
    READY     = 3'd4
  } init_state_t;

  typedef enum logic [1:0] {
    INTA_IDLE  = 2'd0,
    INTA_WAIT2 = 2'd1,
    INTA_VEC   = 2'd2
  } inta_state_t;

  init_state_t state, state_nx;
  inta_state_t inta_state, inta_nx;

  logic wr_prev, inta_prev;
  logic sngl, ic4, sngl_nx, ic4_nx;
  logic wr_event, inta_fall;
  logic icw1_nx, icw2_nx, icw3_nx, icw4_nx;
  logic ocw1_nx, ocw2_nx, ocw3_nx;
  logic inta1_nx, inta2_nx;

  // One event per wrN low period: edge detect on the strobe, gated by chip select.
  assign wr_event  = ~csN & ~wrN & wr_prev;
  assign inta_fall = ~intaN & inta_prev;
  assign initDone  = (state == READY);

  always_comb begin
    state_nx = state;
    inta_nx  = inta_state;
    sngl_nx  = sngl;
    ic4_nx   = ic4;
    icw1_nx  = 1'b0;
    icw2_nx  = 1'b0;
    icw3_nx  = 1'b0;
    icw4_nx  = 1'b0;
    ocw1_nx  = 1'b0;
    ocw2_nx  = 1'b0;
    ocw3_nx  = 1'b0;
    inta1_nx = 1'b0;
    inta2_nx = 1'b0;

    if (wr_event) begin
      if (!A0 && DBus[4]) begin
        icw1_nx  = 1'b1;
        sngl_nx  = DBus[1];
        ic4_nx   = DBus[0];
        state_nx = WAIT_ICW2;
      end else begin
        case (state)
          WAIT_ICW2: if (A0) begin
            icw2_nx = 1'b1;
            if (!sngl)    state_nx = WAIT_ICW3;
            else if (ic4) state_nx = WAIT_ICW4;
            else          state_nx = READY;
          end
          WAIT_ICW3: if (A0) begin
            icw3_nx  = 1'b1;
            state_nx = ic4 ? WAIT_ICW4 : READY;
          end
          WAIT_ICW4: if (A0) begin
            icw4_nx  = 1'b1;
            state_nx = READY;
          end
          READY: begin
            if (A0)           ocw1_nx = 1'b1;
            else if (DBus[3]) ocw3_nx = 1'b1;
            else              ocw2_nx = 1'b1;
          end
          default: ;
        endcase
      end
    end

    // ICW1 restarts initialization and takes priority over any INTA activity.
    if (icw1_nx) begin
      inta_nx = INTA_IDLE;
    end else if (state == READY) begin
      case (inta_state)
        INTA_IDLE: if (inta_fall) begin
          inta1_nx = 1'b1;
          inta_nx  = INTA_WAIT2;
        end
        INTA_WAIT2: if (inta_fall) begin
          inta2_nx = 1'b1;
          inta_nx  = INTA_VEC;
        end
        INTA_VEC: if (intaN) inta_nx = INTA_IDLE;
        default: inta_nx = INTA_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstN) begin
      state      <= IDLE;
      inta_state <= INTA_IDLE;
      wr_prev    <= 1'b1;
      inta_prev  <= 1'b1;
      sngl       <= 1'b0;
      ic4        <= 1'b0;
      wrData     <= 8'h00;
      ICW1flag   <= 1'b0;
      ICW2flag   <= 1'b0;
      ICW3flag   <= 1'b0;
      ICW4flag   <= 1'b0;
      OCW1flag   <= 1'b0;
      OCW2flag   <= 1'b0;
      OCW3flag   <= 1'b0;
      rden       <= 1'b0;
      inta1      <= 1'b0;
      inta2      <= 1'b0;
      vectorOE   <= 1'b0;
    end else begin
      state      <= state_nx;
      inta_state <= inta_nx;
      wr_prev    <= wrN;
      inta_prev  <= intaN;
      sngl       <= sngl_nx;
      ic4        <= ic4_nx;
      if (wr_event) wrData <= DBus;
      ICW1flag   <= icw1_nx;
      ICW2flag   <= icw2_nx;
      ICW3flag   <= icw3_nx;
      ICW4flag   <= icw4_nx;
      OCW1flag   <= ocw1_nx;
      OCW2flag   <= ocw2_nx;
      OCW3flag   <= ocw3_nx;
      rden       <= ~csN & ~rdN;
      inta1      <= inta1_nx;
      inta2      <= inta2_nx;
      vectorOE   <= (inta_nx == INTA_VEC);
    end
  end

endmodule

// File: tb/tb_command_word_sequencer.sv
// tb/tb_command_word_sequencer.sv - directed self-checking bench for command_word_sequencer
module tb_command_word_sequencer;

  logic       clk = 1'b0;
  logic       rstN = 1'b0;
  logic       csN = 1'b1, wrN = 1'b1, rdN = 1'b1, A0 = 1'b0, intaN = 1'b1;
  logic [7:0] DBus = 8'h00;
  logic [7:0] wrData;
  logic       ICW1flag, ICW2flag, ICW3flag, ICW4flag;
  logic       OCW1flag, OCW2flag, OCW3flag;
  logic       rden, initDone, inta1, inta2, vectorOE;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  command_word_sequencer dut (
    .clk(clk), .rstN(rstN), .csN(csN), .wrN(wrN), .rdN(rdN), .A0(A0),
    .DBus(DBus), .intaN(intaN), .wrData(wrData),
    .ICW1flag(ICW1flag), .ICW2flag(ICW2flag), .ICW3flag(ICW3flag), .ICW4flag(ICW4flag),
    .OCW1flag(OCW1flag), .OCW2flag(OCW2flag), .OCW3flag(OCW3flag),
    .rden(rden), .initDone(initDone), .inta1(inta1), .inta2(inta2), .vectorOE(vectorOE)
  );

  // Flag vector order: ICW1 ICW2 ICW3 ICW4 OCW1 OCW2 OCW3
  function automatic logic [6:0] flags();
    return {ICW1flag, ICW2flag, ICW3flag, ICW4flag, OCW1flag, OCW2flag, OCW3flag};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstN = 1'b0; csN = 1'b1; wrN = 1'b1; rdN = 1'b1; intaN = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rstN = 1'b1;
  endtask

  // One-cycle write strobe; checks the pulse pattern, wrData and initDone right after the event edge,
  // then that every flag has dropped one cycle later.
  task automatic wr(input string tag, input logic a0, input logic [7:0] d,
                    input logic [6:0] exp_flags, input logic exp_init);
    @(negedge clk);
    csN = 1'b0; wrN = 1'b0; A0 = a0; DBus = d;
    @(posedge clk);
    @(negedge clk);
    csN = 1'b1; wrN = 1'b1; DBus = 8'hA5; A0 = ~a0;
    chk({tag, "_flags"}, {25'd0, flags()}, {25'd0, exp_flags});
    chk({tag, "_wrdata"}, {24'd0, wrData}, {24'd0, d});
    chk({tag, "_init"}, {31'd0, initDone}, {31'd0, exp_init});
    @(negedge clk);
    chk({tag, "_flags_drop"}, {25'd0, flags()}, 32'd0);
  endtask

  // One intaN low pulse of three cycles.
  task automatic inta_pulse(input string tag, input logic e1, input logic e2, input logic evoe);
    @(negedge clk);
    intaN = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_inta1"}, {31'd0, inta1}, {31'd0, e1});
    chk({tag, "_inta2"}, {31'd0, inta2}, {31'd0, e2});
    chk({tag, "_voe"}, {31'd0, vectorOE}, {31'd0, evoe});
    @(negedge clk);
    @(negedge clk);
    chk({tag, "_pulse_drop"}, {30'd0, inta1, inta2}, 32'd0);
    chk({tag, "_voe_held"}, {31'd0, vectorOE}, {31'd0, evoe});
    intaN = 1'b1;
    @(negedge clk);
    chk({tag, "_voe_off"}, {31'd0, vectorOE}, 32'd0);
  endtask

  initial begin
    int cnt;

    do_reset();
    chk("rst_flags", {25'd0, flags()}, 32'd0);
    chk("rst_misc", {27'd0, rden, initDone, inta1, inta2, vectorOE}, 32'd0);
    chk("rst_wrdata", {24'd0, wrData}, 32'd0);

    // SNGL=1, IC4=1: ICW1, ICW2, ICW4
    wr("a_icw1", 1'b0, 8'h13, 7'b1000000, 1'b0);
    wr("a_icw2", 1'b1, 8'h20, 7'b0100000, 1'b0);
    wr("a_icw4", 1'b1, 8'h01, 7'b0001000, 1'b1);

    // SNGL=0, IC4=0: ICW1, ICW2, ICW3, then OCW1
    wr("b_icw1", 1'b0, 8'h10, 7'b1000000, 1'b0);
    wr("b_icw2", 1'b1, 8'h20, 7'b0100000, 1'b0);
    wr("b_icw3", 1'b1, 8'h04, 7'b0010000, 1'b1);
    wr("b_ocw1", 1'b1, 8'hFB, 7'b0000100, 1'b1);
    wr("c_ocw2", 1'b0, 8'h20, 7'b0000010, 1'b1);
    wr("c_ocw3", 1'b0, 8'h0B, 7'b0000001, 1'b1);

    // wrN held low five cycles: exactly one OCW1 pulse, chip select toggled mid-strobe
    cnt = 0;
    @(negedge clk);
    csN = 1'b0; wrN = 1'b0; A0 = 1'b1; DBus = 8'h55;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      cnt += int'(OCW1flag);
      csN = (i == 2);
    end
    wrN = 1'b1; csN = 1'b1;
    @(negedge clk);
    cnt += int'(OCW1flag);
    chk("long_wr_pulses", cnt, 1);
    chk("long_wr_data", {24'd0, wrData}, 32'h55);

    // rden has one cycle of latency
    @(negedge clk);
    csN = 1'b0; rdN = 1'b0;
    chk("rden_pre", {31'd0, rden}, 32'd0);
    @(negedge clk);
    chk("rden_on", {31'd0, rden}, 32'd1);
    csN = 1'b1; rdN = 1'b1;
    @(negedge clk);
    chk("rden_off", {31'd0, rden}, 32'd0);

    // Ignored write in WAIT_ICW3 keeps state; ICW1 restarts init
    wr("d_icw1", 1'b0, 8'h10, 7'b1000000, 1'b0);
    wr("d_icw2", 1'b1, 8'h20, 7'b0100000, 1'b0);
    wr("d_ign", 1'b0, 8'h20, 7'b0000000, 1'b0);
    wr("d_icw3", 1'b1, 8'h04, 7'b0010000, 1'b1);
    wr("d_rst_icw1", 1'b0, 8'h13, 7'b1000000, 1'b0);
    wr("d_icw2b", 1'b1, 8'h20, 7'b0100000, 1'b0);
    wr("d_icw4", 1'b1, 8'h01, 7'b0001000, 1'b1);

    // INTA sequence in READY
    inta_pulse("inta_first", 1'b1, 1'b0, 1'b0);
    inta_pulse("inta_second", 1'b0, 1'b1, 1'b1);

    // INTA before initialization is ignored
    do_reset();
    inta_pulse("inta_noinit", 1'b0, 1'b0, 1'b0);
    wr("e_idle_ign", 1'b1, 8'h33, 7'b0000000, 1'b0);

    // Reset in WAIT_ICW4 aborts; following A0=1 write is ignored
    wr("f_icw1", 1'b0, 8'h13, 7'b1000000, 1'b0);
    wr("f_icw2", 1'b1, 8'h20, 7'b0100000, 1'b0);
    do_reset();
    chk("f_rst_misc", {27'd0, rden, initDone, inta1, inta2, vectorOE}, 32'd0);
    chk("f_rst_wrdata", {24'd0, wrData}, 32'd0);
    wr("f_after", 1'b1, 8'h01, 7'b0000000, 1'b0);

    // Reset in INTA_VEC
    wr("g_icw1", 1'b0, 8'h12, 7'b1000000, 1'b0);
    wr("g_icw2", 1'b1, 8'h20, 7'b0100000, 1'b1);
    inta_pulse("g_inta_first", 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    intaN = 1'b0;
    @(negedge clk);
    chk("g_voe_on", {31'd0, vectorOE}, 32'd1);
    rstN = 1'b0;
    @(negedge clk);
    chk("g_rst_misc", {27'd0, rden, initDone, inta1, inta2, vectorOE}, 32'd0);
    rstN = 1'b1; intaN = 1'b1;
    wr("g_after", 1'b1, 8'h01, 7'b0000000, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
